// File: rtl/div_msb_iter_pkg.sv
// -----------------------------------------------------------------------------
// div_msb_iter_pkg
// Shared definitions for the leading-one-assisted iterative divider.
//   div_state_t : controller states (IDLE, RUN, DONE)
//   DATA_W      : datapath width, fixed to match the 32-bit leading-one finder
//   CNT_W       : iteration counter width (holds 1..32)
// -----------------------------------------------------------------------------
package div_msb_iter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 6;
    localparam int unsigned POS_W  = 5;

endpackage

// File: rtl/div_msb_iter_msb.sv
// -----------------------------------------------------------------------------
// div_msb_iter_msb
// Combinational leading-one finder for a 32-bit operand.
//   value_i : operand
//   pos_o   : bit index of the most significant set bit (0 when value_i == 0)
// -----------------------------------------------------------------------------
module div_msb_iter_msb
    import div_msb_iter_pkg::*;
(
    input  logic [DATA_W-1:0] value_i,
    output logic [POS_W-1:0]  pos_o
);

    // Ascending scan: the last set bit seen wins, i.e. the highest one.
    always_comb begin
        pos_o = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (value_i[i]) begin
                pos_o = POS_W'(i);
            end
        end
    end

endmodule

// File: rtl/div_msb_iter.sv
// -----------------------------------------------------------------------------
// div_msb_iter
// Unsigned 32-bit restoring radix-2 divider. The leading-one positions of both
// operands set the iteration count to msb(dividend) - msb(divisor) + 1, so
// leading-zero iterations are skipped. Divide-by-zero and dividend < divisor
// resolve in a single cycle.
//   clk             : rising-edge clock
//   rst_n           : asynchronous active-low reset
//   start           : request, accepted when start & ready
//   ready           : high in IDLE and DONE
//   dividend        : unsigned dividend, sampled on acceptance
//   divisor         : unsigned divisor, sampled on acceptance
//   done            : one-cycle pulse, results valid
//   quotient        : result, held from done until next acceptance
//   remainder       : result, held from done until next acceptance
//   divisor_is_zero : flag for the current result
// -----------------------------------------------------------------------------
module div_msb_iter
    import div_msb_iter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              ready,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              divisor_is_zero
);

    div_state_t        state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] div_sh_q, div_sh_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic              dz_q, dz_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;

    logic [POS_W-1:0]  msb_a, msb_b;
    logic [POS_W-1:0]  shift_amt;
    logic [DATA_W-1:0] diff;

    div_msb_iter_msb u_msb_a (
        .value_i (dividend),
        .pos_o   (msb_a)
    );

    div_msb_iter_msb u_msb_b (
        .value_i (divisor),
        .pos_o   (msb_b)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rem_d     = rem_q;
        div_sh_d  = div_sh_q;
        quo_d     = quo_q;
        dz_d      = dz_q;
        // Only consumed on the normal path, where dividend >= divisor > 0
        // guarantees msb_a >= msb_b.
        shift_amt = msb_a - msb_b;
        diff      = rem_q - div_sh_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    if (divisor == '0) begin
                        quo_d   = '1;
                        rem_d   = dividend;
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else if (dividend < divisor) begin
                        quo_d   = '0;
                        rem_d   = dividend;
                        dz_d    = 1'b0;
                        state_d = DONE;
                    end else begin
                        quo_d    = '0;
                        rem_d    = dividend;
                        dz_d     = 1'b0;
                        div_sh_d = divisor << shift_amt;
                        count_d  = {1'b0, shift_amt} + CNT_W'(1);
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                if (rem_q >= div_sh_q) begin
                    rem_d = diff;
                    quo_d = {quo_q[DATA_W-2:0], 1'b1};
                end else begin
                    quo_d = {quo_q[DATA_W-2:0], 1'b0};
                end
                div_sh_d = div_sh_q >> 1;
                count_d  = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d != RUN);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            rem_q    <= '0;
            div_sh_q <= '0;
            quo_q    <= '0;
            dz_q     <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rem_q    <= rem_d;
            div_sh_q <= div_sh_d;
            quo_q    <= quo_d;
            dz_q     <= dz_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    assign ready           = ready_q;
    assign done            = done_q;
    assign quotient        = quo_q;
    assign remainder       = rem_q;
    assign divisor_is_zero = dz_q;

endmodule
